// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, opcodes, FSM states and decode actions for the LCD RAM writer
package lcd_pkg;

    localparam int LCD_COLS   = 132;
    localparam int LCD_PAGES  = 9;
    localparam int LCD_ADDR_W = 11;

    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;
    localparam logic [7:0] CMD_START    = 8'h40;
    localparam logic [7:0] CMD_CONTRAST = 8'h81;
    localparam logic [7:0] CMD_ADC      = 8'hA0;
    localparam logic [7:0] CMD_ALL_ON   = 8'hA4;
    localparam logic [7:0] CMD_INVERT   = 8'hA6;
    localparam logic [7:0] CMD_DISP     = 8'hAE;
    localparam logic [7:0] CMD_PAGE     = 8'hB0;
    localparam logic [7:0] CMD_RMW      = 8'hE0;
    localparam logic [7:0] CMD_RESET    = 8'hE2;
    localparam logic [7:0] CMD_RMW_END  = 8'hEE;

    localparam logic [5:0] CONTRAST_RST = 6'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_ARG
    } lcd_state_t;

    // One-hot command action; all zero means the opcode is a no-op.
    typedef struct packed {
        logic col_lo;
        logic col_hi;
        logic page;
        logic start;
        logic disp;
        logic adc;
        logic invert;
        logic all_on;
        logic contrast;
        logic soft_reset;
        logic rmw;
        logic rmw_end;
    } lcd_act_t;

endpackage

// File: rtl/lcd_cmd_decode.sv
// rtl/lcd_cmd_decode.sv - combinational opcode decode into one-hot action and extracted fields
//  Ports: i_op (command byte) -> o_act (one-hot action), o_nibble (op[3:0]),
//         o_line (op[5:0]), o_flag (op[0]).
//  RMW_EN selects whether E0/EE decode as read-modify-write commands or no-ops.
module lcd_cmd_decode
    import lcd_pkg::*;
#(
    parameter bit RMW_EN = 1'b0
) (
    input  logic [7:0] i_op,
    output lcd_act_t   o_act,
    output logic [3:0] o_nibble,
    output logic [5:0] o_line,
    output logic       o_flag
);

    assign o_nibble = i_op[3:0];
    assign o_line   = i_op[5:0];
    assign o_flag   = i_op[0];

    always_comb begin
        o_act = '0;
        if (i_op[7:4] == CMD_COL_LO[7:4])       o_act.col_lo     = 1'b1;
        else if (i_op[7:4] == CMD_COL_HI[7:4])  o_act.col_hi     = 1'b1;
        else if (i_op[7:6] == CMD_START[7:6])   o_act.start      = 1'b1;
        else if (i_op[7:4] == CMD_PAGE[7:4])    o_act.page       = 1'b1;
        else if (i_op[7:1] == CMD_ADC[7:1])     o_act.adc        = 1'b1;
        else if (i_op[7:1] == CMD_ALL_ON[7:1])  o_act.all_on     = 1'b1;
        else if (i_op[7:1] == CMD_INVERT[7:1])  o_act.invert     = 1'b1;
        else if (i_op[7:1] == CMD_DISP[7:1])    o_act.disp       = 1'b1;
        else if (i_op == CMD_CONTRAST)          o_act.contrast   = 1'b1;
        else if (i_op == CMD_RESET)             o_act.soft_reset = 1'b1;
        else if (i_op == CMD_RMW)               o_act.rmw        = RMW_EN;
        else if (i_op == CMD_RMW_END)           o_act.rmw_end    = RMW_EN;
    end

endmodule

// File: rtl/lcd_ram_writer.sv
// rtl/lcd_ram_writer.sv - CPU-side SED1565-style command/data writer for the LCD display RAM
//  Bus side: i_cs, i_a0 (0 cmd/status, 1 data), i_wr, i_rd, i_din -> o_dout, o_dout_valid, o_busy.
//  VRAM side: o_vram_addr, o_vram_we, o_vram_wdata, o_vram_re, i_vram_rdata (1-cycle read latency).
//  Scan-out controls: o_display_on, o_start_line, o_column_reverse, o_invert, o_all_on, o_contrast.
//  i_reset is asynchronous active-low. Define LCD_RMW_EN to enable E0/EE read-modify-write mode.
module lcd_ram_writer
    import lcd_pkg::*;
#(
    parameter int COLS   = LCD_COLS,
    parameter int PAGES  = LCD_PAGES,
    parameter int ADDR_W = LCD_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cs,
    input  logic              i_a0,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [7:0]        i_din,
    output logic [7:0]        o_dout,
    output logic              o_dout_valid,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic              o_vram_we,
    output logic [7:0]        o_vram_wdata,
    output logic              o_vram_re,
    input  logic [7:0]        i_vram_rdata,
    output logic              o_display_on,
    output logic [5:0]        o_start_line,
    output logic              o_column_reverse,
    output logic              o_invert,
    output logic              o_all_on,
    output logic [5:0]        o_contrast
);

`ifdef LCD_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    localparam logic [7:0] COL_MAX  = 8'(COLS - 1);
    localparam logic [3:0] PAGE_MAX = 4'(PAGES - 1);

    lcd_state_t        r_state, w_state_nxt;
    logic              r_busy, w_busy_nxt;
    logic [7:0]        r_dout, w_dout_nxt;
    logic              r_dout_valid, w_dout_valid_nxt;
    logic [ADDR_W-1:0] r_vram_addr, w_vram_addr_nxt;
    logic              r_vram_we, w_vram_we_nxt;
    logic [7:0]        r_vram_wdata, w_vram_wdata_nxt;
    logic              r_vram_re, w_vram_re_nxt;
    logic              r_disp_on, w_disp_on_nxt;
    logic [5:0]        r_start_line, w_start_line_nxt;
    logic              r_adc, w_adc_nxt;
    logic              r_invert, w_invert_nxt;
    logic              r_all_on, w_all_on_nxt;
    logic [5:0]        r_contrast, w_contrast_nxt;
    logic [3:0]        r_page, w_page_nxt;
    logic [7:0]        r_col, w_col_nxt;
    logic [7:0]        r_latch, w_latch_nxt;
    logic              r_reset_flag, w_reset_flag_nxt;
    logic              r_rmw, w_rmw_nxt;
    logic [7:0]        r_saved_col, w_saved_col_nxt;

    lcd_act_t          w_act;
    logic [3:0]        w_nibble;
    logic [5:0]        w_line;
    logic              w_flag;
    logic              w_accept;
    logic              w_soft;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [7:0]        w_col_inc;
    logic [7:0]        w_col_lo;
    logic [7:0]        w_col_hi;

    lcd_cmd_decode #(.RMW_EN(RMW_EN)) u_cmd_decode (
        .i_op     (i_din),
        .o_act    (w_act),
        .o_nibble (w_nibble),
        .o_line   (w_line),
        .o_flag   (w_flag)
    );

    assign w_accept   = i_cs & (i_wr | i_rd) & ~r_busy;
    assign w_cur_addr = ADDR_W'(r_page) * ADDR_W'(COLS) + ADDR_W'(r_col);
    // Column never wraps into the next page; it sticks at the last column.
    assign w_col_inc  = (r_col >= COL_MAX) ? COL_MAX : r_col + 8'd1;
    assign w_col_lo   = {r_col[7:4], w_nibble};
    assign w_col_hi   = {w_nibble, r_col[3:0]};

    always_comb begin
        w_state_nxt      = r_state;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = 1'b0;
        w_vram_addr_nxt  = r_vram_addr;
        w_vram_we_nxt    = 1'b0;
        w_vram_wdata_nxt = r_vram_wdata;
        w_vram_re_nxt    = 1'b0;
        w_disp_on_nxt    = r_disp_on;
        w_start_line_nxt = r_start_line;
        w_adc_nxt        = r_adc;
        w_invert_nxt     = r_invert;
        w_all_on_nxt     = r_all_on;
        w_contrast_nxt   = r_contrast;
        w_page_nxt       = r_page;
        w_col_nxt        = r_col;
        w_latch_nxt      = r_latch;
        w_reset_flag_nxt = 1'b0;
        w_rmw_nxt        = r_rmw;
        w_saved_col_nxt  = r_saved_col;
        w_soft           = 1'b0;

        case (r_state)
            ST_WR_DATA:    w_state_nxt = ST_IDLE;
            ST_RD_ISSUE:   w_state_nxt = ST_RD_CAPTURE;
            ST_RD_CAPTURE: begin
                w_latch_nxt = i_vram_rdata;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                // IDLE and ARG both accept accesses; a data access abandons a pending ARG.
                if (w_accept) begin
                    if (i_a0 && i_wr) begin
                        w_vram_we_nxt    = 1'b1;
                        w_vram_addr_nxt  = w_cur_addr;
                        w_vram_wdata_nxt = i_din;
                        w_col_nxt        = w_col_inc;
                        w_state_nxt      = ST_WR_DATA;
                    end else if (i_a0) begin
                        // Buffered read: hand out the previous fetch, start the next one.
                        w_dout_nxt       = r_latch;
                        w_dout_valid_nxt = 1'b1;
                        w_vram_re_nxt    = 1'b1;
                        w_vram_addr_nxt  = w_cur_addr;
                        w_col_nxt        = r_rmw ? r_col : w_col_inc;
                        w_state_nxt      = ST_RD_ISSUE;
                    end else if (i_wr && r_state == ST_ARG) begin
                        if (w_act.soft_reset) w_soft = 1'b1;
                        else                  w_contrast_nxt = i_din[5:0];
                        w_state_nxt = ST_IDLE;
                    end else if (i_wr) begin
                        if (w_act.col_lo)   w_col_nxt = (w_col_lo > COL_MAX) ? COL_MAX : w_col_lo;
                        if (w_act.col_hi)   w_col_nxt = (w_col_hi > COL_MAX) ? COL_MAX : w_col_hi;
                        if (w_act.page)     w_page_nxt = (w_nibble > PAGE_MAX) ? PAGE_MAX : w_nibble;
                        if (w_act.start)    w_start_line_nxt = w_line;
                        if (w_act.disp)     w_disp_on_nxt = w_flag;
                        if (w_act.adc)      w_adc_nxt = w_flag;
                        if (w_act.invert)   w_invert_nxt = w_flag;
                        if (w_act.all_on)   w_all_on_nxt = w_flag;
                        if (w_act.contrast) w_state_nxt = ST_ARG;
                        if (w_act.soft_reset) w_soft = 1'b1;
                        if (w_act.rmw) begin
                            w_rmw_nxt       = 1'b1;
                            w_saved_col_nxt = r_col;
                        end
                        if (w_act.rmw_end) begin
                            w_rmw_nxt = 1'b0;
                            w_col_nxt = r_saved_col;
                        end
                    end else begin
                        w_dout_nxt       = {1'b0, r_adc, ~r_disp_on, r_reset_flag, 4'b0000};
                        w_dout_valid_nxt = 1'b1;
                    end
                end
            end
        endcase

        if (w_soft) begin
            w_state_nxt      = ST_IDLE;
            w_dout_nxt       = '0;
            w_vram_addr_nxt  = '0;
            w_vram_wdata_nxt = '0;
            w_disp_on_nxt    = 1'b0;
            w_start_line_nxt = '0;
            w_adc_nxt        = 1'b0;
            w_invert_nxt     = 1'b0;
            w_all_on_nxt     = 1'b0;
            w_contrast_nxt   = CONTRAST_RST;
            w_page_nxt       = '0;
            w_col_nxt        = '0;
            w_latch_nxt      = '0;
            w_rmw_nxt        = 1'b0;
            w_saved_col_nxt  = '0;
            w_reset_flag_nxt = 1'b1;
        end

        w_busy_nxt = (w_state_nxt == ST_WR_DATA) || (w_state_nxt == ST_RD_ISSUE) ||
                     (w_state_nxt == ST_RD_CAPTURE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_vram_addr  <= '0;
            r_vram_we    <= 1'b0;
            r_vram_wdata <= '0;
            r_vram_re    <= 1'b0;
            r_disp_on    <= 1'b0;
            r_start_line <= '0;
            r_adc        <= 1'b0;
            r_invert     <= 1'b0;
            r_all_on     <= 1'b0;
            r_contrast   <= CONTRAST_RST;
            r_page       <= '0;
            r_col        <= '0;
            r_latch      <= '0;
            r_reset_flag <= 1'b0;
            r_rmw        <= 1'b0;
            r_saved_col  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_vram_addr  <= w_vram_addr_nxt;
            r_vram_we    <= w_vram_we_nxt;
            r_vram_wdata <= w_vram_wdata_nxt;
            r_vram_re    <= w_vram_re_nxt;
            r_disp_on    <= w_disp_on_nxt;
            r_start_line <= w_start_line_nxt;
            r_adc        <= w_adc_nxt;
            r_invert     <= w_invert_nxt;
            r_all_on     <= w_all_on_nxt;
            r_contrast   <= w_contrast_nxt;
            r_page       <= w_page_nxt;
            r_col        <= w_col_nxt;
            r_latch      <= w_latch_nxt;
            r_reset_flag <= w_reset_flag_nxt;
            r_rmw        <= w_rmw_nxt;
            r_saved_col  <= w_saved_col_nxt;
        end
    end

    assign o_dout           = r_dout;
    assign o_dout_valid     = r_dout_valid;
    assign o_busy           = r_busy;
    assign o_vram_addr      = r_vram_addr;
    assign o_vram_we        = r_vram_we;
    assign o_vram_wdata     = r_vram_wdata;
    assign o_vram_re        = r_vram_re;
    assign o_display_on     = r_disp_on;
    assign o_start_line     = r_start_line;
    assign o_column_reverse = r_adc;
    assign o_invert         = r_invert;
    assign o_all_on         = r_all_on;
    assign o_contrast       = r_contrast;

endmodule

// File: tb/tb_lcd_ram_writer.sv
// tb/tb_lcd_ram_writer.sv - directed self-checking bench for lcd_ram_writer
module tb_lcd_ram_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, a0 = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        dout_valid, busy;
    logic [10:0] vram_addr;
    logic        vram_we, vram_re;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;
    logic        display_on, column_reverse, invert, all_on;
    logic [5:0]  start_line, contrast;

    logic [7:0]  mem [0:2047];
    logic        pre_en = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          wr_count = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          snap;

    always #5 clk = ~clk;

    lcd_ram_writer dut (
        .i_clk(clk), .i_reset(rst_n), .i_cs(cs), .i_a0(a0), .i_wr(wr), .i_rd(rd), .i_din(din),
        .o_dout(dout), .o_dout_valid(dout_valid), .o_busy(busy),
        .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_wdata(vram_wdata),
        .o_vram_re(vram_re), .i_vram_rdata(vram_rdata),
        .o_display_on(display_on), .o_start_line(start_line), .o_column_reverse(column_reverse),
        .o_invert(invert), .o_all_on(all_on), .o_contrast(contrast)
    );

    // VRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
            wr_count <= wr_count + 1;
        end
        if (vram_re) vram_rdata <= mem[vram_addr];
    end

    // Drives one strobe for exactly one rising edge; returns 1ns after that edge.
    task automatic bus(input logic a, input logic w, input logic r, input logic [7:0] d);
        cs = 1'b1; a0 = a; wr = w; rd = r; din = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d); bus(1'b0, 1'b1, 1'b0, d); endtask
    task automatic dwr(input logic [7:0] d); bus(1'b1, 1'b1, 1'b0, d); endtask
    task automatic drd(); bus(1'b1, 1'b0, 1'b1, 8'h00); endtask
    task automatic srd(); bus(1'b0, 1'b0, 1'b1, 8'h00); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
        n_chk++; if (dout_valid !== 1'b0) $display("FAIL rst_dv got %0b exp 0", dout_valid); else n_pass++;
        n_chk++; if (contrast !== 6'h20) $display("FAIL rst_contrast got %h exp 20", contrast); else n_pass++;
        n_chk++; if (display_on !== 1'b0) $display("FAIL rst_disp got %0b exp 0", display_on); else n_pass++;
        n_chk++; if (start_line !== 6'h00) $display("FAIL rst_start got %h exp 00", start_line); else n_pass++;
        n_chk++; if (vram_we !== 1'b0) $display("FAIL rst_we got %0b exp 0", vram_we); else n_pass++;
    endtask

    task automatic test_data_write();
        cmd(8'hB2); cmd(8'h10); cmd(8'h05); dwr(8'hAA);
        n_chk++; if (vram_we !== 1'b1) $display("FAIL wr_we got %0b exp 1", vram_we); else n_pass++;
        n_chk++; if (vram_addr !== 11'd269) $display("FAIL wr_addr got %0d exp 269", vram_addr); else n_pass++;
        n_chk++; if (vram_wdata !== 8'hAA) $display("FAIL wr_data got %h exp AA", vram_wdata); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy got %0b exp 1", busy); else n_pass++;
        idle(1);
        n_chk++; if (vram_we !== 1'b0 || busy !== 1'b0) $display("FAIL wr_done we %0b busy %0b exp 0 0", vram_we, busy); else n_pass++;
        dwr(8'h55);
        n_chk++; if (vram_addr !== 11'd270) $display("FAIL wr_col6 got %0d exp 270", vram_addr); else n_pass++;
        idle(1);
    endtask

    task automatic test_data_read();
        pre_en = 1'b1; pre_addr = 11'd269; pre_data = 8'h5C;
        cmd(8'hB2);
        pre_en = 1'b0;
        cmd(8'h10); cmd(8'h05); drd();
        n_chk++; if (dout_valid !== 1'b1) $display("FAIL rd1_dv got %0b exp 1", dout_valid); else n_pass++;
        n_chk++; if (dout !== 8'h00) $display("FAIL rd1_dummy got %h exp 00", dout); else n_pass++;
        n_chk++; if (vram_re !== 1'b1 || vram_addr !== 11'd269) $display("FAIL rd1_re re %0b addr %0d exp 1 269", vram_re, vram_addr); else n_pass++;
        idle(1);
        n_chk++; if (busy !== 1'b1 || dout_valid !== 1'b0) $display("FAIL rd1_cap busy %0b dv %0b exp 1 0", busy, dout_valid); else n_pass++;
        idle(1);
        n_chk++; if (busy !== 1'b0) $display("FAIL rd1_end busy got %0b exp 0", busy); else n_pass++;
        drd();
        n_chk++; if (dout !== 8'h5C) $display("FAIL rd2_data got %h exp 5C", dout); else n_pass++;
        idle(2);
        dwr(8'h01);
        n_chk++; if (vram_addr !== 11'd271) $display("FAIL rd_col7 got %0d exp 271", vram_addr); else n_pass++;
        idle(1);
    endtask

    task automatic test_status_regs();
        srd();
        n_chk++; if (dout_valid !== 1'b1 || dout !== 8'h20) $display("FAIL stat1 dv %0b dout %h exp 1 20", dout_valid, dout); else n_pass++;
        cmd(8'hAF); cmd(8'hA1); cmd(8'h55); cmd(8'hA7); cmd(8'hA5); srd();
        n_chk++; if (dout !== 8'h40) $display("FAIL stat2 got %h exp 40", dout); else n_pass++;
        n_chk++; if (display_on !== 1'b1) $display("FAIL disp_on got %0b exp 1", display_on); else n_pass++;
        n_chk++; if (column_reverse !== 1'b1) $display("FAIL adc got %0b exp 1", column_reverse); else n_pass++;
        n_chk++; if (start_line !== 6'h15) $display("FAIL start got %h exp 15", start_line); else n_pass++;
        n_chk++; if (invert !== 1'b1 || all_on !== 1'b1) $display("FAIL inv_all got %0b%0b exp 11", invert, all_on); else n_pass++;
    endtask

    task automatic test_col_saturate();
        cmd(8'hB3); cmd(8'h18); cmd(8'h03); dwr(8'h11);
        n_chk++; if (vram_addr !== 11'd527 || vram_wdata !== 8'h11) $display("FAIL sat1 addr %0d data %h exp 527 11", vram_addr, vram_wdata); else n_pass++;
        idle(1); dwr(8'h22);
        n_chk++; if (vram_addr !== 11'd527 || vram_wdata !== 8'h22) $display("FAIL sat2 addr %0d data %h exp 527 22", vram_addr, vram_wdata); else n_pass++;
        idle(1); cmd(8'h1F); cmd(8'h0F); dwr(8'h33);
        n_chk++; if (vram_addr !== 11'd527) $display("FAIL col_clamp got %0d exp 527", vram_addr); else n_pass++;
        idle(1); cmd(8'hBF); cmd(8'h10); cmd(8'h00); dwr(8'h44);
        n_chk++; if (vram_addr !== 11'd1056) $display("FAIL page_clamp got %0d exp 1056", vram_addr); else n_pass++;
        idle(1);
    endtask

    task automatic test_contrast_soft_reset();
        cmd(8'h81); cmd(8'h3F);
        n_chk++; if (contrast !== 6'h3F) $display("FAIL contrast got %h exp 3F", contrast); else n_pass++;
        cmd(8'h81); cmd(8'hE2);
        n_chk++; if (contrast !== 6'h20) $display("FAIL sr_contrast got %h exp 20", contrast); else n_pass++;
        n_chk++; if (display_on !== 1'b0 || column_reverse !== 1'b0) $display("FAIL sr_regs disp %0b adc %0b exp 0 0", display_on, column_reverse); else n_pass++;
        n_chk++; if (start_line !== 6'h00 || invert !== 1'b0 || all_on !== 1'b0) $display("FAIL sr_misc start %h inv %0b all %0b exp 00 0 0", start_line, invert, all_on); else n_pass++;
        srd();
        n_chk++; if (dout !== 8'h30) $display("FAIL sr_flag got %h exp 30", dout); else n_pass++;
        srd();
        n_chk++; if (dout !== 8'h20) $display("FAIL sr_flag_clr got %h exp 20", dout); else n_pass++;
        cmd(8'hB2); cmd(8'h10); cmd(8'h05); drd();
        n_chk++; if (dout !== 8'h00) $display("FAIL sr_latch got %h exp 00", dout); else n_pass++;
        idle(2); drd();
        n_chk++; if (dout !== 8'h5C) $display("FAIL sr_vram_kept got %h exp 5C", dout); else n_pass++;
        idle(2);
    endtask

    task automatic test_back_to_back();
        cmd(8'hB0); cmd(8'h10); cmd(8'h00);
        snap = wr_count;
        dwr(8'h99); dwr(8'h66);
        n_chk++; if (vram_we !== 1'b0) $display("FAIL busy_ignore we got %0b exp 0", vram_we); else n_pass++;
        idle(1);
        n_chk++; if (wr_count - snap !== 1) $display("FAIL busy_count got %0d exp 1", wr_count - snap); else n_pass++;
        dwr(8'h12);
        n_chk++; if (vram_addr !== 11'd1) $display("FAIL busy_col got %0d exp 1", vram_addr); else n_pass++;
        idle(1);
        bus(1'b1, 1'b1, 1'b1, 8'h5A);
        n_chk++; if (vram_we !== 1'b1 || vram_re !== 1'b0 || dout_valid !== 1'b0) $display("FAIL wr_rd we %0b re %0b dv %0b exp 1 0 0", vram_we, vram_re, dout_valid); else n_pass++;
        n_chk++; if (vram_addr !== 11'd2 || vram_wdata !== 8'h5A) $display("FAIL wr_rd addr %0d data %h exp 2 5A", vram_addr, vram_wdata); else n_pass++;
        idle(1);
        drd(); drd();
        n_chk++; if (dout_valid !== 1'b0) $display("FAIL rd_busy dv got %0b exp 0", dout_valid); else n_pass++;
        idle(1);
        snap = wr_count;
        cs = 1'b0; a0 = 1'b1; wr = 1'b1; din = 8'hEE;
        @(posedge clk); #1; wr = 1'b0;
        idle(1);
        n_chk++; if (wr_count !== snap) $display("FAIL cs_low got %0d writes exp 0", wr_count - snap); else n_pass++;
    endtask

    task automatic test_rmw();
        int exp1, exp2;
`ifdef LCD_RMW_EN
        exp1 = 10; exp2 = 10;
`else
        exp1 = 12; exp2 = 13;
`endif
        cmd(8'hB0); cmd(8'h10); cmd(8'h0A); cmd(8'hE0);
        drd(); idle(2); drd(); idle(2);
        dwr(8'h77);
        n_chk++; if (vram_addr !== 11'(exp1)) $display("FAIL rmw_wr got %0d exp %0d", vram_addr, exp1); else n_pass++;
        idle(1); cmd(8'hEE); dwr(8'h88);
        n_chk++; if (vram_addr !== 11'(exp2)) $display("FAIL rmw_end got %0d exp %0d", vram_addr, exp2); else n_pass++;
        idle(1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_data_write();
        test_data_read();
        test_status_regs();
        test_col_saturate();
        test_contrast_soft_reset();
        test_back_to_back();
        test_rmw();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
